// File: rtl/apb_slave_if.sv
// APB completer bus bundle: requester-driven request signals and completer responses.
// Parameters must match those of the apb_slave instance attached to it.
interface apb_slave_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [2:0]            prot;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    output pwrite, addr, psel, penable, pwdata, prot,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  pwrite, addr, psel, penable, pwdata, prot,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_slave.sv
// APB completer with a 2**ADDR_WIDTH-word register file and fixed wait states.
// Optional APB_SLAVE_PROT_CHECK_EN: reject non-secure (prot[1]=1) transfers with pslverr.
//
// state  | meaning
// IDLE   | no transfer in flight; waiting for a SETUP cycle (psel=1, penable=0)
// ACCESS | request latched; counting wait states, pready high on the last one
module apb_slave #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         resetn,
  apb_slave_if.slave   bus
);

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [3:0]            cnt_inc;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_reject;
  logic                  reject_in;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef APB_SLAVE_PROT_CHECK_EN
  always_comb begin
    reject_in = bus.prot[1];
  end
`else
  wire unused_prot = ^bus.prot;
  always_comb begin
    reject_in = 1'b0;
  end
`endif

  always_comb begin
    cnt_inc = cnt + 4'd1;
  end

  // pready/pslverr are registered so that pready_q always equals (ACCESS && cnt == WS).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_write  <= 1'b0;
      lat_wdata  <= '0;
      lat_reject <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.psel && !bus.penable) begin
      // SETUP from IDLE, or a fresh SETUP while in ACCESS: relatch and restart
      state      <= ACCESS;
      cnt        <= '0;
      lat_addr   <= bus.addr;
      lat_write  <= bus.pwrite;
      lat_wdata  <= bus.pwdata;
      lat_reject <= reject_in;
      pready_q   <= (WS == 4'd0);
      pslverr_q  <= (WS == 4'd0) && reject_in;
      if (!bus.pwrite) begin
        prdata_q <= reject_in ? '0 : mem[bus.addr];
      end
    end else if (state == ACCESS && bus.psel && bus.penable) begin
      if (pready_q) begin
        state     <= IDLE;
        pready_q  <= 1'b0;
        pslverr_q <= 1'b0;
        if (lat_write && !lat_reject) begin
          mem[lat_addr] <= lat_wdata;
        end
      end else begin
        cnt       <= cnt_inc;
        pready_q  <= (cnt_inc == WS);
        pslverr_q <= (cnt_inc == WS) && lat_reject;
        if (!lat_write) begin
          prdata_q <= lat_reject ? '0 : mem[lat_addr];
        end
      end
    end else begin
      // idle, abort (psel dropped), or psel&penable without a SETUP
      state     <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: two instances (WAIT_STATES=0 and 3) share one request bus.
module tb_apb_slave;

`ifdef APB_SLAVE_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  apb_slave_if b0 ();
  apb_slave_if b3 ();

  assign b3.psel    = b0.psel;
  assign b3.penable = b0.penable;
  assign b3.pwrite  = b0.pwrite;
  assign b3.addr    = b0.addr;
  assign b3.pwdata  = b0.pwdata;
  assign b3.prot    = b0.prot;

  apb_slave #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .bus(b0)
  );
  apb_slave #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .bus(b3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer; which=1 observes the WAIT_STATES=3 instance.
  task automatic xfer(input bit which, input bit w, input logic [4:0] a,
                      input logic [31:0] d, input logic [2:0] p,
                      output logic [31:0] rd, output logic err, output int waits);
    logic rdy;
    b0.psel = 1'b1; b0.penable = 1'b0; b0.pwrite = w;
    b0.addr = a; b0.pwdata = d; b0.prot = p;
    waits = 0; rd = '0; err = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      rdy = which ? b3.pready : b0.pready;
      b0.penable = 1'b1;
      if (rdy) begin
        rd  = which ? b3.prdata : b0.prdata;
        err = which ? b3.pslverr : b0.pslverr;
        step();
        b0.psel = 1'b0; b0.penable = 1'b0;
        return;
      end
      waits++;
      step();
    end
    chk("xfer_timeout", 32'(waits), 32'd0);
    b0.psel = 1'b0; b0.penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits;
  int          pulses;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    b0.psel = 1'b0; b0.penable = 1'b0; b0.pwrite = 1'b0;
    b0.addr = '0; b0.pwdata = '0; b0.prot = '0;
    step(); step();
    chk("rst_pready", {31'd0, b0.pready}, 32'd0);
    chk("rst_pslverr", {31'd0, b0.pslverr}, 32'd0);
    chk("rst_prdata", b0.prdata, 32'd0);
    resetn = 1'b1;
    step();

    // secure write then read, no wait states
    xfer(0, 1, 5'd1, 32'h12153524, 3'b000, rd, err, waits);
    chk("wr1_waits", 32'(waits), 32'd0);
    chk("wr1_err", {31'd0, err}, 32'd0);
    chk("wr1_pready_drop", {31'd0, b0.pready}, 32'd0);
    xfer(0, 0, 5'd1, 32'h0, 3'b000, rd, err, waits);
    chk("rd1_data", rd, 32'h12153524);
    chk("rd1_err", {31'd0, err}, 32'd0);
    step(); step();
    chk("rd1_hold", b0.prdata, 32'h12153524);

    // non-secure read and write
    xfer(0, 0, 5'd1, 32'h0, 3'b010, rd, err, waits);
    chk("ns_rd_err", {31'd0, err}, PROT_EN ? 32'd1 : 32'd0);
    chk("ns_rd_data", rd, PROT_EN ? 32'h0 : 32'h12153524);
    xfer(0, 1, 5'd1, 32'hDEADBEEF, 3'b010, rd, err, waits);
    chk("ns_wr_err", {31'd0, err}, PROT_EN ? 32'd1 : 32'd0);
    xfer(0, 0, 5'd1, 32'h0, 3'b000, rd, err, waits);
    chk("ns_wr_after", rd, PROT_EN ? 32'h12153524 : 32'hDEADBEEF);

    // a write does not disturb prdata
    xfer(0, 1, 5'd2, 32'h00000055, 3'b000, rd, err, waits);
    chk("wr_keeps_prdata", b0.prdata, PROT_EN ? 32'h12153524 : 32'hDEADBEEF);

    // penable held past completion: exactly one pready pulse
    b0.psel = 1'b1; b0.penable = 1'b0; b0.pwrite = 1'b1;
    b0.addr = 5'd3; b0.pwdata = 32'hA5A5F00F; b0.prot = 3'b000;
    pulses = 0;
    step();
    if (b0.pready) pulses++;
    b0.penable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (b0.pready) pulses++;
    end
    chk("ext_pulses", 32'(pulses), 32'd1);
    b0.psel = 1'b0; b0.penable = 1'b0;
    xfer(0, 0, 5'd3, 32'h0, 3'b000, rd, err, waits);
    chk("ext_rd", rd, 32'hA5A5F00F);

    // psel&penable without SETUP is ignored
    b0.psel = 1'b1; b0.penable = 1'b1;
    step();
    chk("nosetup_pready_a", {31'd0, b0.pready}, 32'd0);
    step();
    chk("nosetup_pready_b", {31'd0, b0.pready}, 32'd0);
    b0.psel = 1'b0; b0.penable = 1'b0;
    step();

    // repeated SETUP in ACCESS relatches the request
    b0.psel = 1'b1; b0.penable = 1'b0; b0.pwrite = 1'b1;
    b0.addr = 5'd4; b0.pwdata = 32'h00001111;
    step();
    b0.addr = 5'd5; b0.pwdata = 32'h00002222;
    step();
    chk("resetup_pready", {31'd0, b0.pready}, 32'd1);
    b0.penable = 1'b1;
    step();
    b0.psel = 1'b0; b0.penable = 1'b0;
    xfer(0, 0, 5'd4, 32'h0, 3'b000, rd, err, waits);
    chk("resetup_old_addr", rd, 32'h0);
    xfer(0, 0, 5'd5, 32'h0, 3'b000, rd, err, waits);
    chk("resetup_new_addr", rd, 32'h00002222);

    // abort: psel dropped in ACCESS
    b0.psel = 1'b1; b0.penable = 1'b0; b0.pwrite = 1'b1;
    b0.addr = 5'd6; b0.pwdata = 32'h00003333;
    step();
    b0.psel = 1'b0;
    step();
    chk("abort_pready", {31'd0, b0.pready}, 32'd0);
    xfer(0, 0, 5'd6, 32'h0, 3'b000, rd, err, waits);
    chk("abort_no_write", rd, 32'h0);

    // three wait states
    xfer(1, 1, 5'd7, 32'h77777777, 3'b000, rd, err, waits);
    chk("ws3_wr_waits", 32'(waits), 32'd3);
    chk("ws3_wr_err", {31'd0, err}, 32'd0);
    xfer(1, 0, 5'd7, 32'h0, 3'b000, rd, err, waits);
    chk("ws3_rd_waits", 32'(waits), 32'd3);
    chk("ws3_rd_data", rd, 32'h77777777);

    // asynchronous reset in the middle of a write
    xfer(0, 0, 5'd5, 32'h0, 3'b000, rd, err, waits);
    chk("pre_rst_prdata", b0.prdata, 32'h00002222);
    b0.psel = 1'b1; b0.penable = 1'b0; b0.pwrite = 1'b1;
    b0.addr = 5'd1; b0.pwdata = 32'hCAFEF00D;
    step();
    b0.penable = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_pready", {31'd0, b0.pready}, 32'd0);
    chk("mid_rst_pslverr", {31'd0, b0.pslverr}, 32'd0);
    chk("mid_rst_prdata", b0.prdata, 32'd0);
    chk("mid_rst_prdata3", b3.prdata, 32'd0);
    b0.psel = 1'b0; b0.penable = 1'b0;
    step();
    resetn = 1'b1;
    step();
    xfer(0, 0, 5'd1, 32'h0, 3'b000, rd, err, waits);
    chk("post_rst_addr1", rd, 32'h0);
    xfer(0, 0, 5'd5, 32'h0, 3'b000, rd, err, waits);
    chk("post_rst_addr5", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
